// File: rtl/clock_div_pkg.sv
// Shared state encoding and default widths for the programmable serial-clock divider.
package clock_div_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEF_DIV_W = 16;
    localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/clk_div_tick.sv
// Loadable half-period counter: counts 0..half_div_l while enabled and flags the wrap cycle.
// o_wrap is combinational from registered state, so the consumer registers the resulting edge.
module clk_div_tick
    import clock_div_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [DIV_W-1:0] i_half_div,
    input  logic             i_en,
    output logic             o_wrap
);

    localparam logic [DIV_W-1:0] ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    logic [DIV_W-1:0] r_half_l;
    logic [DIV_W-1:0] r_cnt;

    assign o_wrap = i_en && (r_cnt == r_half_l);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_half_l <= '0;
            r_cnt    <= '0;
        end else if (i_load) begin
            r_half_l <= i_half_div;
            r_cnt    <= '0;
        end else if (i_en) begin
            // Explicit wrap keeps an all-ones half_div from relying on overflow.
            if (o_wrap) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + ONE;
            end
        end
    end

endmodule

// File: rtl/clock_div_prog.sv
// Programmable serial-clock generator with CPOL, burst length and single-cycle edge strobes.
// Optional CLK_DIV_CYC_CNT_EN adds o_cyc_done (completed periods of current/last burst).
module clock_div_prog
    import clock_div_pkg::*;
#(
    parameter int CLK_IN = 120000000,
    parameter int DIV_W  = DEF_DIV_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic             i_clk_in,
    input  logic             i_rst,
    input  logic [DIV_W-1:0] i_half_div,
    input  logic             i_cpol,
    input  logic [CNT_W-1:0] i_n_cycles,
    input  logic             i_start,
    input  logic             i_stop,
    output logic             o_clk_out,
    output logic             o_rise_tick,
    output logic             o_fall_tick,
    output logic             o_busy,
    output logic             o_done
`ifdef CLK_DIV_CYC_CNT_EN
   ,output logic [CNT_W-1:0] o_cyc_done
`endif
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    if (CLK_IN <= 0) begin : g_bad_clk_in
        $error("clock_div_prog: CLK_IN must be positive");
    end

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_clk_out;
    logic             r_rise;
    logic             r_fall;
    logic             r_done;
    logic             r_stop_pend;
    logic             r_cpol_l;
    logic [CNT_W-1:0] r_n_l;
    logic [CNT_W-1:0] r_cyc_cnt;

    logic             w_wrap;
    logic             w_run;
    logic             w_load;
    logic             w_trail;
    logic             w_end;
    logic [CNT_W-1:0] w_cyc_nxt;

    assign w_run = (r_state == RUN);

    clk_div_tick #(
        .DIV_W (DIV_W)
    ) u_tick (
        .i_clk      (i_clk_in),
        .i_rst      (i_rst),
        .i_load     (w_load),
        .i_half_div (i_half_div),
        .i_en       (w_run),
        .o_wrap     (w_wrap)
    );

    always_ff @(posedge i_clk_in) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_end       = 1'b0;
        w_trail     = w_wrap && (r_clk_out != r_cpol_l);
        w_cyc_nxt   = (r_cyc_cnt == '1) ? r_cyc_cnt : (r_cyc_cnt + CNT_ONE);
        case (r_state)
            IDLE: begin
                // The done cycle still reports busy, so a start there is refused too.
                if (i_start && !r_done) begin
                    w_load      = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_trail && (((r_n_l != '0) && (w_cyc_nxt == r_n_l)) || r_stop_pend || i_stop)) begin
                    w_end       = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk_in) begin
        if (i_rst) begin
            r_clk_out   <= 1'b0;
            r_rise      <= 1'b0;
            r_fall      <= 1'b0;
            r_done      <= 1'b0;
            r_stop_pend <= 1'b0;
            r_cpol_l    <= 1'b0;
            r_n_l       <= '0;
            r_cyc_cnt   <= '0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            r_done <= w_end;
            if (!w_run) begin
                r_clk_out <= i_cpol;
                if (w_load) begin
                    r_cpol_l    <= i_cpol;
                    r_n_l       <= i_n_cycles;
                    r_cyc_cnt   <= '0;
                    r_stop_pend <= 1'b0;
                end
            end else begin
                if (w_wrap) begin
                    r_clk_out <= ~r_clk_out;
                    r_rise    <= ~r_clk_out;
                    r_fall    <= r_clk_out;
                end
                if (w_trail) begin
                    r_cyc_cnt <= w_cyc_nxt;
                end
                // Stop only arms here; the burst ends on the next trailing edge.
                if (i_stop) begin
                    r_stop_pend <= 1'b1;
                end
            end
        end
    end

    assign o_clk_out   = r_clk_out;
    assign o_rise_tick = r_rise;
    assign o_fall_tick = r_fall;
    assign o_busy      = w_run || r_done;
    assign o_done      = r_done;
`ifdef CLK_DIV_CYC_CNT_EN
    assign o_cyc_done  = r_cyc_cnt;
`endif

endmodule

// File: doc/clock_div_prog.md
Name: clock_div_prog

Overview:
- Runtime-programmable serial-clock generator, successor of the fixed divider.
- Produces a divided clock with programmable half-period, idle polarity (CPOL) and burst length.
- Emits single-cycle rise/fall strobes so SPI shift logic stays in the clk_in domain.
- Sits between a protocol controller (SPI master FSM) and the pad; one instance per serial channel.

Parameters:
- CLK_IN, 120000000, input clock frequency in Hz (documentation and defaults only; no logic depends on it).
- DIV_W, 16, width of half_div; maximum half-period is 2^DIV_W clk_in cycles.
- CNT_W, 8, width of n_cycles burst counter.

Ports:
- clk_in  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- half_div  in  DIV_W  half-period length minus 1; output period = 2*(half_div+1) clk_in cycles.
- cpol  in  1  idle level of clk_out.
- n_cycles  in  CNT_W  full clk_out periods per burst; 0 = free-run until stop.
- start  in  1  single-cycle request to begin a burst.
- stop  in  1  single-cycle request to end a free-run or burst early.
- clk_out  out  1  generated clock, registered.
- rise_tick  out  1  high in the same cycle clk_out goes 0->1.
- fall_tick  out  1  high in the same cycle clk_out goes 1->0.
- busy  out  1  high while in RUN.
- done  out  1  single-cycle pulse on burst completion.

Behaviour:
- Reset values: clk_out=0, rise_tick=0, fall_tick=0, busy=0, done=0, internal counters=0, state=IDLE.
- States are IDLE and RUN.
- IDLE:
  - clk_out <= cpol every cycle.
  - start=1 latches half_div, n_cycles and cpol, clears counters, and moves to RUN. busy=1 from the next cycle.
- RUN:
  - Half-period counter runs 0..half_div_l.
  - When it reaches half_div_l: counter wraps to 0, clk_out toggles, and the matching tick asserts in that same registered cycle.
  - First toggle (leading edge, away from cpol_l) occurs exactly half_div_l+1 cycles after the start cycle.
- Period accounting:
  - A trailing edge (back to cpol_l) completes one period and increments cyc_cnt.
  - If n_cycles_l != 0 and cyc_cnt reaches n_cycles_l, on that trailing edge: done=1 in the same cycle, state -> IDLE, busy=0 the next cycle.
- stop in RUN:
  - Sets a pending-stop flag.
  - The block finishes the current period; at the next trailing edge: done=1 and -> IDLE.
  - clk_out never ends at the non-idle level and never produces a runt pulse.
  - If stop coincides with a trailing edge, that edge ends the burst.
- Ignored inputs and edge cases:
  - stop in IDLE is ignored.
  - start while busy is ignored.
  - start and stop in the same IDLE cycle: start is accepted, stop is dropped.
  - half_div, cpol and n_cycles changes while busy have no effect (latched values only).
  - half_div=0: clk_out toggles every cycle (clk_in/2), ticks alternate each cycle.
  - Maximum half_div: the counter wraps without overflow.
- rst mid-burst: immediate return to the reset values; no done pulse.
- rise_tick and fall_tick are never high together. done only coincides with a trailing-edge tick.

Optional Feature:
- Macro CLK_DIV_CYC_CNT_EN.
- Defined: adds output cyc_done [CNT_W], the completed-period count of the current or last burst.
  - Cleared on start.
  - Holds its value in IDLE.
  - Saturates at all-ones in free-run.
- Undefined: port absent. cyc_cnt exists only as needed for burst termination, behaviour otherwise identical.

Decomposition:
- Package clock_div_pkg holds:
  - state enum (IDLE, RUN);
  - default DIV_W and CNT_W constants.
- One sub-module, clk_div_tick: loadable half-period counter with a wrap strobe. The top module holds the FSM, polarity, burst count and strobes.

Test Plan:
- Free-run: half_div=2, cpol=0, n_cycles=0, start.
  - First rise 3 cycles after start; period 6 cycles.
  - stop mid-high: clk_out completes the period low, done 1 cycle, busy drops next cycle.
- Burst: half_div=0, cpol=1, n_cycles=4.
  - clk_out idles 1; exactly 4 falls and 4 rises.
  - done coincides with the 4th rise_tick.
  - clk_out ends at 1, busy low after.
- Latch check: during a burst of half_div=5, change half_div to 1 and cpol to 1.
  - Period stays 12 cycles.
  - After done, clk_out follows the new cpol=1 in IDLE.
- Collisions:
  - start while busy: no restart.
  - start+stop in the same IDLE cycle: burst runs to n_cycles=3.
  - stop during IDLE: no effect.
- Reset mid-burst: assert rst during the high phase.
  - Next cycle: clk_out=0, busy=0, no done.
  - A new start behaves like from power-up.
- With CLK_DIV_CYC_CNT_EN defined:
  - n_cycles=7 burst: cyc_done reads 7 after done.
  - Free-run with CNT_W=3: saturates at 7.
